// File: rtl/cc_alu_stage.sv
// Execute-stage ALU for the integer OP class: registers the result bus and owns the
// ZF/SF/OF condition-code register, with stall/bubble control and a CC-in-flight flag.
module cc_alu_stage #(
    parameter logic [3:0]  OP_ICODE  = 4'b0100,
    parameter logic [3:0]  NOP_ICODE = 4'b0000,
    parameter int unsigned W         = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inValid,
    input  logic [3:0]   insCode,
    input  logic [3:0]   funCode,
    input  logic [W-1:0] aluA,
    input  logic [W-1:0] aluB,
    input  logic         stall,
    input  logic         bubble,
    output logic         outValid,
    output logic [3:0]   outInsCode,
    output logic [3:0]   outFunCode,
    output logic [W-1:0] aluE_e,
    output logic         zf,
    output logic         sf,
    output logic         of,
    output logic         ccPending,
    output logic         badFun
);

    logic         is_op;
    logic         fun_ok;
    logic [W-1:0] add_r;
    logic [W-1:0] sub_r;
    logic [W-1:0] op_r;
    logic         op_of;

    logic         valid_q, valid_d;
    logic [3:0]   ins_q, ins_d;
    logic [3:0]   fun_q, fun_d;
    logic [W-1:0] alu_q, alu_d;
    logic         zf_q, zf_d;
    logic         sf_q, sf_d;
    logic         of_q, of_d;
    logic         bad_q, bad_d;

    assign is_op  = (insCode == OP_ICODE);
    assign fun_ok = (funCode <= 4'd3);
    assign add_r  = aluA + aluB;
    assign sub_r  = aluA - aluB;

    always_comb begin
        op_r  = '0;
        op_of = 1'b0;
        case (funCode)
            4'd0: begin
                op_r  = add_r;
                op_of = (aluA[W-1] == aluB[W-1]) && (add_r[W-1] != aluA[W-1]);
            end
            4'd1: begin
                op_r  = sub_r;
                op_of = (aluA[W-1] != aluB[W-1]) && (sub_r[W-1] != aluA[W-1]);
            end
            4'd2:    op_r = aluA & aluB;
            4'd3:    op_r = aluA ^ aluB;
            default: op_r = '0;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        ins_d   = ins_q;
        fun_d   = fun_q;
        alu_d   = alu_q;
        zf_d    = zf_q;
        sf_d    = sf_q;
        of_d    = of_q;
        // Pulse by default so a held badFun never stretches across a stall.
        bad_d   = 1'b0;
        if (stall) begin
            // hold everything
        end else if (bubble || !inValid) begin
            valid_d = 1'b0;
            ins_d   = NOP_ICODE;
            fun_d   = 4'd0;
            alu_d   = '0;
        end else begin
            valid_d = 1'b1;
            ins_d   = insCode;
            fun_d   = funCode;
            if (is_op && fun_ok) begin
                alu_d = op_r;
                zf_d  = (op_r == '0);
                sf_d  = op_r[W-1];
                of_d  = op_of;
            end else if (is_op) begin
                alu_d = '0;
                bad_d = 1'b1;
            end else begin
                alu_d = add_r;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ins_q   <= NOP_ICODE;
            fun_q   <= 4'd0;
            alu_q   <= '0;
            zf_q    <= 1'b1;
            sf_q    <= 1'b0;
            of_q    <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ins_q   <= ins_d;
            fun_q   <= fun_d;
            alu_q   <= alu_d;
            zf_q    <= zf_d;
            sf_q    <= sf_d;
            of_q    <= of_d;
            bad_q   <= bad_d;
        end
    end

    // Stall deliberately absent: a stalled OP still owes its CC write.
    assign ccPending  = inValid & is_op & fun_ok & ~bubble & ~rst;

    assign outValid   = valid_q;
    assign outInsCode = ins_q;
    assign outFunCode = fun_q;
    assign aluE_e     = alu_q;
    assign zf         = zf_q;
    assign sf         = sf_q;
    assign of         = of_q;
    assign badFun     = bad_q;

endmodule

// File: doc/cc_alu_stage.md
Name: cc_alu_stage

Overview:
- Execute-stage producer of the condition information consumed by the jump-condition logic.
- Performs the 8-bit integer OP instructions and registers the result bus `aluE_e`.
- Maintains the architectural condition-code register: ZF, SF, OF.
- Honours pipeline stall/bubble control, and flags in-flight CC updates so the branch stage can interlock.

Parameters:
- OP_ICODE, 4'b0100, insCode value of the integer OP instruction class (the only class that writes CCs).
- NOP_ICODE, 4'b0000, insCode injected downstream on a bubble.
- W, 8, datapath width; SF is bit W-1 of the result.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- inValid  in  1  input stage holds a real instruction
- insCode  in  4  instruction class of input instruction
- funCode  in  4  function code of input instruction
- aluA  in  W  operand A
- aluB  in  W  operand B
- stall  in  1  hold all state this cycle
- bubble  in  1  inject NOP into output stage this cycle
- outValid  out  1  registered instruction valid
- outInsCode  out  4  registered insCode
- outFunCode  out  4  registered funCode
- aluE_e  out  W  registered ALU result
- zf  out  1  zero flag (CC register)
- sf  out  1  sign flag (CC register)
- of  out  1  signed-overflow flag (CC register)
- ccPending  out  1  combinational: a CC write commits at the next edge
- badFun  out  1  registered one-cycle pulse: OP with an unsupported funCode

Behaviour:
- All state updates on the rising edge of clk.
- Update priority per edge: rst > stall > bubble > inValid > idle.
- Reset values:
  - outValid=0, outInsCode=NOP_ICODE, outFunCode=0, aluE_e=0, badFun=0.
  - zf=1, sf=0, of=0.
- stall=1:
  - Every register holds, including the CCs.
  - badFun is forced 0, so its pulse is not stretched.
  - A simultaneous bubble is ignored.
- bubble=1 (stall=0):
  - outValid=0, outInsCode=NOP_ICODE, outFunCode=0, aluE_e=0.
  - CCs hold, even if the input is a valid OP; the squashed OP must not commit.
- inValid=1, no stall/bubble:
  - outValid=1; outInsCode/outFunCode capture the inputs.
  - Latency from input to aluE_e and to the CCs is exactly 1 cycle.
- OP functions, all modulo 2^W, operands treated as two's complement:
  - funCode 0 ADD: r=aluA+aluB; of=(aluA[W-1]==aluB[W-1]) && (r[W-1]!=aluA[W-1]).
  - funCode 1 SUB: r=aluA-aluB; of=(aluA[W-1]!=aluB[W-1]) && (r[W-1]!=aluA[W-1]).
  - funCode 2 AND: r=aluA&aluB; of=0.
  - funCode 3 XOR: r=aluA^aluB; of=0.
  - For these four: zf=(r==0), sf=r[W-1], aluE_e=r.
- insCode==OP_ICODE with funCode>3:
  - aluE_e=0; CCs hold; badFun=1 for one cycle.
- Non-OP valid instruction:
  - aluE_e=aluA+aluB, used for address/pass-through; CCs hold.
- inValid=0, no stall/bubble:
  - Same as bubble: outValid=0, NOP injected, CCs hold.
- ccPending = inValid & (insCode==OP_ICODE) & (funCode<=3) & ~bubble & ~rst.
  - Stall does not clear it: the write is still outstanding.
- Back-to-back OPs: each edge commits the newest CCs; no flag merging.
- Reset asserted mid-stream discards any pending CC write.
- Consumers sampling zf/aluE_e[W-1] see CCs that are one instruction behind any OP whose ccPending is high; the branch stage stalls on ccPending.

Test Plan:
- Reset: hold rst 2 cycles -> zf=1, sf=0, of=0, outValid=0, aluE_e=0, outInsCode=0.
- ADD overflow: OP f0, aluA=8'h7F, aluB=8'h01 -> next cycle aluE_e=8'h80, sf=1, of=1, zf=0; ccPending high during the input cycle only.
- SUB to zero, then XOR: OP f1, 8'h05-8'h05 -> aluE_e=0, zf=1, sf=0, of=0. Next, OP f3 8'hF0^8'h0F -> aluE_e=8'hFF, sf=1, zf=0.
- Stall/bubble:
  - OP f0 8'h01+8'h01 with stall=1 for 3 cycles -> outputs and CCs frozen, ccPending stays 1.
  - Release stall -> aluE_e=8'h02, zf=0.
  - Same OP with bubble=1 -> outValid=0, CCs unchanged.
- Bad funCode: OP f7 -> badFun pulse of exactly 1 cycle, aluE_e=0, CCs unchanged. Non-OP insCode 4'b0101 with 8'h10+8'h20 -> aluE_e=8'h30, CCs unchanged.
- Reset mid-operation: assert rst in the same cycle as a valid OP (8'h80-8'h01) -> after the edge zf=1, sf=0, of=0 (the OP's flags 0/0/1 never appear).
